hash_table_arbiter: RTL

- Shares one hash-table AXI-style wrapper (32-bit command word: [31:30] opcode, key, data) between NUM_REQUESTERS independent command streams.
- Round-robin arbitration feeds a single registered command slot toward the table.
- A tag FIFO records the requester of each issued read. In-order read responses from the table are routed back to the correct requester.
- Sits directly in front of the table wrapper; requesters are host/DMA command ports.

---
 rtl/hash_table_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hash_table_arbiter.sv
// Round-robin front end that shares one hash-table command port between several
// requesters and routes in-order read responses back through a tag FIFO.
module hash_table_arbiter #(
   parameter int NUM_REQUESTERS  = 4,
   parameter int WORD_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQUESTERS-1:0]            req_valid_i,
   output logic [NUM_REQUESTERS-1:0]            req_ready_o,
   output logic [WORD_WIDTH-1:0]                rsp_data_o,
   output logic [NUM_REQUESTERS-1:0]            rsp_valid_o,
   input  logic [NUM_REQUESTERS-1:0]            rsp_ready_i,
   output logic [WORD_WIDTH-1:0]                tbl_data_o,
   output logic                                 tbl_valid_o,
   input  logic                                 tbl_ready_i,
   input  logic [WORD_WIDTH-1:0]                tbl_data_i,
   input  logic                                 tbl_valid_i,
   output logic                                 tbl_ready_o,
   output logic                                 err_unexp_rsp_o,
   output logic [7:0]                           drop_cnt_o
);

   localparam int RR_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      OP_ILLEGAL_LO = 2'b00,
      OP_READ       = 2'b01,
      OP_WRITE      = 2'b10,
      OP_ILLEGAL_HI = 2'b11
   } opcode_t;

   logic [WORD_WIDTH-1:0]     cmd_q;
   logic                      cmd_v;
   logic [RR_W-1:0]           rr_ptr;
   logic [RR_W-1:0]           tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          count;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      slot_free;
   logic [NUM_REQUESTERS-1:0] eligible;
   logic                      grant_v;
   logic [RR_W-1:0]           grant_idx;
   logic [WORD_WIDTH-1:0]     grant_word;
   opcode_t                   grant_op;
   logic                      grant_legal;
   logic                      push;
   logic                      pop;
   logic                      unexp;
   logic [RR_W-1:0]           head;
   logic                      err_q;
   logic [7:0]                drop_q;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign slot_free       = !cmd_v || tbl_ready_i;
   assign fifo_full       = (count == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty      = (count == '0);
   assign tbl_valid_o     = cmd_v;
   assign tbl_data_o      = cmd_q;
   assign err_unexp_rsp_o = err_q;
   assign drop_cnt_o      = drop_q;

   // A read is held back only by the registered count, so a pop this cycle frees space next cycle.
   always_comb begin
      eligible = '0;
      for (int unsigned r = 0; r < NUM_REQUESTERS; r++) begin
         eligible[r] = req_valid_i[r] &&
            !((req_data_i[r*WORD_WIDTH + WORD_WIDTH - 2 +: 2] == OP_READ) && fifo_full);
      end
   end

   always_comb begin
      int unsigned idx;
      grant_v   = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         idx = (32'(rr_ptr) + i) % NUM_REQUESTERS;
         if (!grant_v && slot_free && !reset && eligible[idx]) begin
            grant_v   = 1'b1;
            grant_idx = RR_W'(idx);
         end
      end
   end

   always_comb begin
      grant_word  = req_data_i[grant_idx*WORD_WIDTH +: WORD_WIDTH];
      grant_op    = opcode_t'(grant_word[WORD_WIDTH-1 -: 2]);
      grant_legal = (grant_op == OP_READ) || (grant_op == OP_WRITE);
      push        = grant_v && (grant_op == OP_READ);
      req_ready_o = '0;
      if (grant_v) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      head        = tag_mem[rd_ptr];
      rsp_data_o  = tbl_data_i;
      rsp_valid_o = '0;
      tbl_ready_o = 1'b1;
      pop         = 1'b0;
      unexp       = 1'b0;
      if (!fifo_empty) begin
         tbl_ready_o = rsp_ready_i[head];
         pop         = tbl_valid_i && rsp_ready_i[head];
         if (!reset) begin
            rsp_valid_o[head] = tbl_valid_i;
         end
      end else begin
         unexp = tbl_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q  <= '0;
         cmd_v  <= 1'b0;
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         if (slot_free) begin
            cmd_v <= 1'b0;
            if (grant_v) begin
               rr_ptr <= (grant_idx == RR_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
               if (grant_legal) begin
                  cmd_q <= grant_word;
                  cmd_v <= 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_q <= drop_q + 8'd1;
               end
            end
         end
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (unexp) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
